// File: rtl/kyber_pkg.sv
// kyber_pkg: shared Kyber512 constants and packer FSM state type
package kyber_pkg;
  localparam int KYBER_Q = 3329;
  localparam int KYBER_DU = 10;
  localparam int KYBER_DV = 4;
  localparam int KYBER_N = 256;
  localparam int U_WORDS = 64;
  localparam int V_WORDS = 32;
  localparam int CT_BEATS = 192;
  typedef enum logic [2:0] {IDLE, RD, LAT, CMP, APPEND, DRAIN, DONE} state_t;
endpackage

// File: rtl/enc_compress_pack_if.sv
// enc_compress_pack_if: Add BRAM read port plus ciphertext valid/ready stream
interface enc_compress_pack_if;
  logic [7:0] Add_RAd;
  logic [127:0] Add_RData;
  logic [31:0] ct_tdata;
  logic ct_tvalid;
  logic ct_tready;
  logic ct_tlast;
  modport master (output Add_RAd, ct_tdata, ct_tvalid, ct_tlast, input Add_RData, ct_tready);
  modport slave (input Add_RAd, ct_tdata, ct_tvalid, ct_tlast, output Add_RData, ct_tready);
endinterface

// File: rtl/kyber_compress.sv
// kyber_compress: combinational Kyber compress of one coefficient to D bits
module kyber_compress import kyber_pkg::*; #(
  parameter int D = KYBER_DU
) (
  input  logic [15:0]  coeff,
  output logic [D-1:0] res
);
  localparam logic [11:0] Q12 = 12'(KYBER_Q);
  logic [11:0] xr;
  logic [31:0] quo;
  logic unused_bits;
  // reduce the sum below Q once, then round x*2^D/Q to nearest
  always_comb begin
    xr = coeff[11:0] >= Q12 ? coeff[11:0] - Q12 : coeff[11:0];
    quo = ((32'(xr) << D) + 32'(KYBER_Q / 2)) / 32'(KYBER_Q);
  end
  assign res = quo[D-1:0];
  assign unused_bits = ^{coeff[15:12], quo[31:D]};
endmodule

// File: rtl/enc_compress_pack.sv
// enc_compress_pack: compresses u/v words from the Add BRAM and packs them into a 32-bit stream
module enc_compress_pack import kyber_pkg::*; (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  enc_compress_pack_if.master bus,
  output logic busy,
  output logic Function_done
);
  logic [79:0] cu;
  logic [31:0] cv;
  state_t state;
  logic [6:0] addr;
  logic [79:0] chunk;
  logic is_u;
  logic [95:0] buffer;
  logic [6:0] count;
  logic [7:0] beat;
  logic [95:0] appended;
  logic [95:0] shifted;
  logic [6:0] rem;
  genvar j;
  for (j = 0; j < 8; j++) begin : g_lane
    kyber_compress #(.D(KYBER_DU)) u_cu (.coeff(bus.Add_RData[16*j +: 16]), .res(cu[KYBER_DU*j +: KYBER_DU]));
    kyber_compress #(.D(KYBER_DV)) u_cv (.coeff(bus.Add_RData[16*j +: 16]), .res(cv[KYBER_DV*j +: KYBER_DV]));
  end
  // buffer after appending the pending chunk, and after popping one beat
  always_comb begin
    appended = buffer | ({16'd0, chunk} << count);
    shifted = buffer >> 32;
    rem = count - 7'd32;
  end
  // frame sequencer: read a word, compress it, append, then drain whole beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      addr <= '0;
      chunk <= '0;
      is_u <= 1'b0;
      buffer <= '0;
      count <= '0;
      beat <= '0;
      busy <= 1'b0;
      Function_done <= 1'b0;
      bus.Add_RAd <= '0;
      bus.ct_tdata <= '0;
      bus.ct_tvalid <= 1'b0;
      bus.ct_tlast <= 1'b0;
    end else begin
      Function_done <= 1'b0;
      case (state)
        IDLE: if (enable) begin
          state <= RD;
          busy <= 1'b1;
          addr <= '0;
          buffer <= '0;
          count <= '0;
          beat <= '0;
        end
        RD: begin
          bus.Add_RAd <= {1'b0, addr};
          state <= LAT;
        end
        LAT: state <= CMP;
        CMP: begin
          is_u <= addr < 7'(U_WORDS);
          chunk <= addr < 7'(U_WORDS) ? cu : {48'd0, cv};
          state <= APPEND;
        end
        APPEND: begin
          buffer <= appended;
          count <= count + (is_u ? 7'(8 * KYBER_DU) : 7'(8 * KYBER_DV));
          bus.ct_tdata <= appended[31:0];
          bus.ct_tvalid <= 1'b1;
          bus.ct_tlast <= beat == 8'(CT_BEATS - 1);
          state <= DRAIN;
        end
        DRAIN: if (bus.ct_tready) begin
          buffer <= shifted;
          count <= rem;
          beat <= beat + 8'd1;
          bus.ct_tdata <= shifted[31:0];
          bus.ct_tlast <= rem >= 7'd32 && beat == 8'(CT_BEATS - 2);
          if (rem < 7'd32) begin
            bus.ct_tvalid <= 1'b0;
            if (addr == 7'(U_WORDS + V_WORDS - 1)) state <= DONE;
            else begin
              addr <= addr + 7'd1;
              state <= RD;
            end
          end
        end
        DONE: begin
          Function_done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_enc_compress_pack.sv
// tb_enc_compress_pack: directed vector table plus multi-cycle corner sequences for the ciphertext packer
module tb_enc_compress_pack;
  logic clk = 0;
  logic rst_n = 0;
  logic enable = 0;
  logic busy, done;
  enc_compress_pack_if bus();
  enc_compress_pack dut (.clk(clk), .rst_n(rst_n), .enable(enable), .bus(bus.master), .busy(busy), .Function_done(done));

  always #5 clk = ~clk;

  logic [127:0] mem [96];
  always @(posedge clk) bus.Add_RData <= (bus.Add_RAd < 8'd96) ? mem[bus.Add_RAd] : '0;

  int ready_pct = 100;
  initial begin
    bus.ct_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2 bus.ct_tready = ($urandom_range(0, 99) < ready_pct);
    end
  end

  int checks = 0, errors = 0;
  logic [31:0] cap [192];
  logic [31:0] exp_b [192];
  int cap_n, last_cnt, last_pos, done_cnt, ad_steps, ad_bad;
  logic [7:0] last_ad;
  logic stall_prev = 0;
  logic [31:0] pd;
  logic pl;

  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev) begin
        checks++;
        if (!(bus.ct_tvalid && bus.ct_tdata == pd && bus.ct_tlast == pl)) begin
          errors++;
          $display("FAIL stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b", bus.ct_tvalid, bus.ct_tdata, bus.ct_tlast, pd, pl);
        end
      end
      if (bus.ct_tvalid && bus.ct_tready) begin
        if (cap_n < 192) cap[cap_n] = bus.ct_tdata;
        if (bus.ct_tlast) begin
          last_cnt++;
          last_pos = cap_n;
        end
        cap_n++;
      end
      stall_prev = bus.ct_tvalid && !bus.ct_tready;
      pd = bus.ct_tdata;
      pl = bus.ct_tlast;
      if (done) done_cnt++;
      if (bus.Add_RAd != last_ad) begin
        if (bus.Add_RAd != 8'd0) begin
          ad_steps++;
          if (bus.Add_RAd != last_ad + 8'd1) ad_bad++;
        end
        last_ad = bus.Add_RAd;
      end
    end else stall_prev = 0;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic int comp(input int x, input int d);
    int y;
    y = x & 'hfff;
    if (y >= 3329) y -= 3329;
    return (((y << d) + 1664) / 3329) % (1 << d);
  endfunction

  task automatic build_model();
    logic [6143:0] s;
    int pos, d, c;
    s = '0;
    pos = 0;
    for (int w = 0; w < 96; w++)
      for (int l = 0; l < 8; l++) begin
        d = w < 64 ? 10 : 4;
        c = comp(int'(mem[w][16*l +: 16]), d);
        for (int b = 0; b < d; b++) s[pos + b] = c[b];
        pos += d;
      end
    for (int k = 0; k < 192; k++) exp_b[k] = s[32*k +: 32];
  endtask

  task automatic start_frame();
    @(posedge clk);
    #2 enable = 1;
    cap_n = 0; last_cnt = 0; last_pos = -1; done_cnt = 0; ad_steps = 0; ad_bad = 0;
    last_ad = bus.Add_RAd;
    @(posedge clk);
    #2 enable = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 5000 && done_cnt == 0; i++) @(posedge clk);
    repeat (5) @(posedge clk);
  endtask

  task automatic check_frame(input string tag);
    int bad, first;
    bad = 0;
    first = -1;
    for (int k = 0; k < 192; k++)
      if (cap[k] !== exp_b[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    chk($sformatf("%s beat_count", tag), 64'(cap_n), 64'd192);
    chk($sformatf("%s beat_mismatches(first=%0d)", tag, first), 64'(bad), 64'd0);
    chk($sformatf("%s done_pulses", tag), 64'(done_cnt), 64'd1);
    chk($sformatf("%s tlast_count", tag), 64'(last_cnt), 64'd1);
    chk($sformatf("%s tlast_pos", tag), 64'(last_pos), 64'd191);
    chk($sformatf("%s addr_steps", tag), 64'(ad_steps), 64'd95);
    chk($sformatf("%s addr_order_errs", tag), 64'(ad_bad), 64'd0);
    chk($sformatf("%s busy_after", tag), 64'(busy), 64'd0);
  endtask

  typedef struct {
    string name;
    logic [127:0] w0;
    logic [127:0] w64;
    int beat;
    logic [31:0] expv;
  } vec_t;
  vec_t vecs [7];

  initial begin
    vecs[0] = '{"zeros", 128'd0, 128'd0, 191, 32'h00000000};
    vecs[1] = '{"u_mixed_b0", {16'd0, 16'd0, 16'd3329, 16'd3328, 16'd1664, 16'd2, 16'd1, 16'd0}, 128'd0, 0, 32'h00100000};
    vecs[2] = '{"u_mixed_b1", {16'd0, 16'd0, 16'd3329, 16'd3328, 16'd1664, 16'd2, 16'd1, 16'd0}, 128'd0, 1, 32'h00000080};
    vecs[3] = '{"v_half", 128'd0, {8{16'd1664}}, 160, 32'h88888888};
    vecs[4] = '{"v_wrap", 128'd0, {8{16'd3328}}, 160, 32'h00000000};
    vecs[5] = '{"u_hinib_sub", {8{16'hF005}}, 128'd0, 0, 32'h80200802};
    vecs[6] = '{"u_half", {8{16'd1664}}, 128'd0, 0, 32'h20080200};
    for (int w = 0; w < 96; w++) mem[w] = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst Add_RAd", 64'(bus.Add_RAd), 64'd0);
    chk("rst tdata", 64'(bus.ct_tdata), 64'd0);
    chk("rst tvalid", 64'(bus.ct_tvalid), 64'd0);
    chk("rst tlast", 64'(bus.ct_tlast), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    rst_n = 1;

    ready_pct = 100;
    for (int v = 0; v < 7; v++) begin
      for (int w = 0; w < 96; w++) mem[w] = '0;
      mem[0] = vecs[v].w0;
      mem[64] = vecs[v].w64;
      build_model();
      start_frame();
      chk($sformatf("%s busy_on", vecs[v].name), 64'(busy), 64'd1);
      wait_done();
      chk($sformatf("%s beat%0d", vecs[v].name, vecs[v].beat), 64'(cap[vecs[v].beat]), 64'(vecs[v].expv));
      check_frame(vecs[v].name);
    end

    for (int w = 0; w < 96; w++)
      for (int l = 0; l < 8; l++) mem[w][16*l +: 16] = 16'($urandom_range(0, 3328));
    build_model();
    ready_pct = 30;
    start_frame();
    wait_done();
    check_frame("random_bp");

    ready_pct = 100;
    start_frame();
    for (int i = 0; i < 3000 && cap_n < 50; i++) @(negedge clk);
    @(posedge clk);
    #2 enable = 1;
    @(posedge clk);
    #2 enable = 0;
    wait_done();
    check_frame("enable_busy");
    start_frame();
    wait_done();
    check_frame("second_frame");

    ready_pct = 70;
    start_frame();
    for (int i = 0; i < 5000 && cap_n < 100; i++) @(negedge clk);
    chk("abort reached_beat100", 64'(cap_n >= 100), 64'd1);
    #1 rst_n = 0;
    #1;
    chk("abort tvalid", 64'(bus.ct_tvalid), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort tdata", 64'(bus.ct_tdata), 64'd0);
    chk("abort Add_RAd", 64'(bus.Add_RAd), 64'd0);
    repeat (4) @(posedge clk);
    chk("abort no_done", 64'(done_cnt), 64'd0);
    #2 rst_n = 1;
    ready_pct = 100;
    start_frame();
    wait_done();
    check_frame("after_abort");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
